pool_window_feeder: RTL and testbench
=====================================

# pool_window_feeder

Producer side of the second max-pooling stage. Accepts one 8-bit conv-layer result per channel per cycle (8 channels in parallel) over a valid/ready stream and assembles them into 5-sample pooling windows per channel. Each completed window is held in an output register and offered to the pooling array with a valid/ready handshake. It sits between the conv-layer output stream and the 8-unit max-pooling layer, and drives that layer's window inputs and `en`.

## Interface
- `DATA_W`, 8: sample width in bits (signed two's complement).
- `CH`, 8: number of parallel channels.
- `POOL`, 5: window length in samples.
- `STRIDE`, 5: accepted samples between successive window starts; legal range 1..`POOL`.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` and `in_last` are valid.
- `in_ready`  out  1  feeder can accept a sample this cycle.
- `in_data`  in  [CH-1:0][DATA_W-1:0]  one sample per channel.
- `in_last`  in  1  the current sample is the last of its frame.
- `win_valid`  out  1  `win` holds a complete window; also drives pooling `en`.
- `win_ready`  in  1  consumer accepts the window this cycle.
- `win`  out  [CH-1:0][POOL-1:0][DATA_W-1:0]  windows; index 0 is the oldest sample, `POOL-1` the newest.

## Operation
- Accept event: `in_valid && in_ready`. Only accept events change the shift registers and counters.
- `in_ready = rst && (!win_valid || win_ready)`. This is combinational, and it is 0 while reset is asserted.
- Each channel has a `POOL`-deep shift register. On accept, each channel shifts toward index 0, and the new sample enters at `POOL-1`.
- States:
  - FILL: `fill_cnt` counts 0..`POOL`.
    - An accept that makes `fill_cnt == POOL` completes a window, and the state moves to STEADY with `stride_cnt = 0`.
  - STEADY: `stride_cnt` counts accepts.
    - An accept that makes `stride_cnt == STRIDE` completes a window, and `stride_cnt` returns to 0.
- Window completion:
  - The post-shift contents of all channels are loaded into `win`, and `win_valid` is set on the same edge.
  - `win_valid` clears on an edge where `win_ready` is 1, unless a new window completes on that same edge. In that case `win` reloads and `win_valid` stays 1, giving back-to-back windows with no bubble.
- Frame end: on an accept with `in_last = 1`:
  - If that accept also completes a window, the window is emitted normally.
  - Afterwards the state returns to FILL with `fill_cnt = 0` and `stride_cnt = 0`.
  - Samples never carry over between frames.
- Leftover samples at frame end, when `in_last` does not complete a window, are handled per `## Configuration`.
- Arithmetic:
  - `fill_cnt` and `stride_cnt` are each `$clog2(POOL+1)` bits wide.
  - Data is never modified, only moved; no width growth.

## Timing
- Latency: `win_valid` is 1 in the cycle after the accept that completes a window.
- Throughput: with `STRIDE = 1` and `win_ready` held at 1, one window per cycle once STEADY is reached.
- Back-pressure:
  - While `win_valid && !win_ready`, `in_ready` is 0.
  - `win` is stable until the window is accepted.
- Reset (async assert, synchronous-safe deassert):
  - Outputs `win_valid = 0`, `win = 0`, `in_ready = 0`.
  - State FILL with both counters 0; shift registers 0.
  - A mid-frame reset discards any partial window and any pending window.
- `in_valid` with `in_ready = 0` has no effect. The source holds `in_data` and `in_last` until accepted.
- `STRIDE` outside 1..`POOL` is unsupported; an elaboration-time assertion flags it.

## Configuration
- `POOL_PAD_EN` defined:
  - An `in_last` accept that does not complete a window, with k > 0 valid samples pending, emits one padded window on the next edge.
  - k is `fill_cnt` in FILL. In STEADY it is `POOL-STRIDE+stride_cnt`, counting only samples accepted since the previous window start + `STRIDE`.
  - `win[c][POOL-k..POOL-1]` hold the newest k samples. `win[c][0..POOL-k-1]` are set to the most negative value (`8'h80` at `DATA_W = 8`), so padding never wins the max.
  - Handshake and latency are as for normal windows.
- `POOL_PAD_EN` not defined:
  - Leftover samples are silently dropped; no window is emitted.

## Test plan
- Reset, then default parameters; feed ch0 = 1,2,3,4,5 with `win_ready` = 1 → `win_valid` = 1 one cycle after the 5th accept, `win[0] = {1,2,3,4,5}` (idx0 = 1), and nothing before that.
- Default parameters, 10 continuous samples → exactly two windows. The second is `{6..10}`, and `win_valid` pulses at accepts 5 and 10.
- `STRIDE` = 1, 8 samples, `win_ready` = 1 → windows after accepts 5, 6, 7 and 8, back-to-back with no bubble; the last is `{4..8}`.
- Stall: hold `win_ready` = 0 after the first window → `in_ready` = 0 and `win` is stable for 3 cycles. Releasing it accepts the window on that edge, and `in_ready` returns to 1.
- Frame of 7 samples, `in_last` on the 7th:
  - Without `POOL_PAD_EN`: 1 window.
  - With `POOL_PAD_EN`: a second window `{80,80,80,6,7}`.
  - The next frame restarts in FILL.
- Assert `rst` = 0 after 3 accepts → outputs zero at once. After release, 5 new samples produce a window containing only post-reset data.

Source files
------------

// File: rtl/pool_window_feeder.sv
// rtl/pool_window_feeder.sv - assembles per-channel POOL-sample windows for the max-pooling stage
// Optional build macro POOL_PAD_EN: emit a padded window for leftover samples at frame end.
module pool_window_feeder #(
    parameter int DATA_W = 8,
    parameter int CH     = 8,
    parameter int POOL   = 5,
    parameter int STRIDE = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [CH-1:0][DATA_W-1:0]            in_data,
    input  logic                                 in_last,
    output logic                                 win_valid,
    input  logic                                 win_ready,
    output logic [CH-1:0][POOL-1:0][DATA_W-1:0]  win
);

    localparam int CW = $clog2(POOL + 1);

    typedef enum logic {S_FILL, S_STEADY} state_t;
    typedef logic [CH-1:0][POOL-1:0][DATA_W-1:0] win_t;

    generate
        if (STRIDE < 1 || STRIDE > POOL) begin : g_bad_stride
            $error("pool_window_feeder: STRIDE must lie in 1..POOL");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [CW-1:0]   fill_cnt_q, fill_cnt_d;
    logic [CW-1:0]   stride_cnt_q, stride_cnt_d;
    win_t            sreg_q, sreg_d;
    win_t            win_q, win_d;
    logic            win_valid_q, win_valid_d;

    win_t            shifted;
    logic [CW-1:0]   fill_inc;
    logic [CW-1:0]   stride_inc;
    logic            accept;
    logic            complete;

    // Reset is folded into the ready term seen by the source; internal
    // acceptance does not need it because the flops are held in reset anyway.
    assign in_ready   = rst && (!win_valid_q || win_ready);
    assign accept     = in_valid && (!win_valid_q || win_ready);
    assign fill_inc   = fill_cnt_q + CW'(1);
    assign stride_inc = stride_cnt_q + CW'(1);
    assign win_valid  = win_valid_q;
    assign win        = win_q;

    // Shift every channel toward index 0 with the incoming sample at the top.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < POOL - 1; i++) begin
                shifted[c][i] = sreg_q[c][i+1];
            end
            shifted[c][POOL-1] = in_data[c];
        end
    end

`ifdef POOL_PAD_EN
    logic [CW-1:0]   pad_k;
    win_t            padded;

    // Newest pad_k samples stay in place; older slots take the most negative value.
    always_comb begin
        pad_k  = (state_q == S_FILL) ? fill_inc : (CW'(POOL - STRIDE) + stride_inc);
        padded = '0;
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < POOL; i++) begin
                if (i + int'(pad_k) >= POOL) begin
                    padded[c][i] = shifted[c][i];
                end else begin
                    padded[c][i] = {1'b1, {(DATA_W-1){1'b0}}};
                end
            end
        end
    end
`endif

    // Counter/state progression and window capture, evaluated only on accepts.
    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        stride_cnt_d = stride_cnt_q;
        sreg_d       = sreg_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q && !win_ready;
        complete     = 1'b0;
        if (accept) begin
            sreg_d = shifted;
            if (state_q == S_FILL) begin
                if (fill_inc == CW'(POOL)) begin
                    complete     = 1'b1;
                    state_d      = S_STEADY;
                    fill_cnt_d   = '0;
                    stride_cnt_d = '0;
                end else begin
                    fill_cnt_d = fill_inc;
                end
            end else begin
                if (stride_inc == CW'(STRIDE)) begin
                    complete     = 1'b1;
                    stride_cnt_d = '0;
                end else begin
                    stride_cnt_d = stride_inc;
                end
            end
            if (complete) begin
                win_d       = shifted;
                win_valid_d = 1'b1;
            end
`ifdef POOL_PAD_EN
            else if (in_last) begin
                win_d       = padded;
                win_valid_d = 1'b1;
            end
`endif
            // A frame boundary always restarts filling from an empty history.
            if (in_last) begin
                state_d      = S_FILL;
                fill_cnt_d   = '0;
                stride_cnt_d = '0;
                sreg_d       = '0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_FILL;
            fill_cnt_q   <= '0;
            stride_cnt_q <= '0;
            sreg_q       <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            stride_cnt_q <= stride_cnt_d;
            sreg_q       <= sreg_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
        end
    end

endmodule

// File: tb/tb_pool_window_feeder.sv
// tb/tb_pool_window_feeder.sv - directed vector bench for pool_window_feeder
module tb_pool_window_feeder;

    localparam int DW = 8;
    localparam int CH = 8;
    localparam int P  = 5;
`ifdef POOL_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    typedef logic [CH-1:0][P-1:0][DW-1:0] win_t;
    typedef logic [P-1:0][DW-1:0]         w0_t;

    typedef struct {
        logic       v;
        logic       last;
        logic [7:0] d;
        logic       wr;
        logic       exp_valid;
        logic       chk_win;
        w0_t        exp_w0;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic win_ready = 1'b1;
    logic [CH-1:0][DW-1:0] in_data = '0;

    logic a_in_ready, a_win_valid, b_in_ready, b_win_valid;
    win_t a_win, b_win;

    int tests = 0;
    int fails = 0;

    vec_t tbl [12];

    always #5 clk = ~clk;

    pool_window_feeder #(.DATA_W(DW), .CH(CH), .POOL(P), .STRIDE(5)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .win_valid(a_win_valid),
        .win_ready(win_ready), .win(a_win)
    );

    pool_window_feeder #(.DATA_W(DW), .CH(CH), .POOL(P), .STRIDE(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .win_valid(b_win_valid),
        .win_ready(win_ready), .win(b_win)
    );

    task automatic chk(input string name, input logic [319:0] got, input logic [319:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic w0_t mkw(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                input logic [7:0] d, input logic [7:0] e);
        w0_t w;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e;
        return w;
    endfunction

    // Channel c carries the ch0 sample plus 16*c.
    function automatic win_t full(input w0_t w);
        win_t r;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < P; i++)
                r[c][i] = w[i] + 8'(16 * c);
        return r;
    endfunction

    task automatic drive(input logic v, input logic last, input logic [7:0] d, input logic wr);
        @(negedge clk);
        in_valid  = v;
        in_last   = last;
        win_ready = wr;
        for (int c = 0; c < CH; c++) in_data[c] = d + 8'(16 * c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        win_t pw;

        for (int i = 0; i < 10; i++) begin
            tbl[i] = '{1'b1, 1'b0, 8'(i + 1), 1'b1, (i == 4 || i == 9), (i == 4 || i == 9),
                       (i == 4) ? mkw(1, 2, 3, 4, 5) : mkw(6, 7, 8, 9, 10)};
        end
        tbl[10] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, mkw(6, 7, 8, 9, 10)};
        tbl[11] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, mkw(0, 0, 0, 0, 0)};

        // Reset state while rst is low
        #12;
        chk("rst_win_valid", a_win_valid, 0);
        chk("rst_win", a_win, 0);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_in_ready_s1", b_in_ready, 0);
        @(negedge clk);
        rst = 1'b1;

        // Table: two windows over 10 continuous samples, then idle
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].last, tbl[i].d, tbl[i].wr);
            chk($sformatf("tbl%0d_valid", i), a_win_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_in_ready", i), a_in_ready, 1);
            if (tbl[i].chk_win) chk($sformatf("tbl%0d_win", i), a_win, full(tbl[i].exp_w0));
        end

        // STRIDE=1: back-to-back windows after accepts 5..8
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            drive(1, 0, 8'(k), 1);
            chk($sformatf("s1_valid_%0d", k), b_win_valid, (k >= 5));
            if (k == 6) chk("s1_win_6", b_win, full(mkw(2, 3, 4, 5, 6)));
            if (k == 8) chk("s1_win_8", b_win, full(mkw(4, 5, 6, 7, 8)));
        end

        // Stall: window held while win_ready is low
        do_reset();
        for (int k = 1; k <= 5; k++) drive(1, 0, 8'(k), 1);
        chk("stall_first_valid", a_win_valid, 1);
        for (int s = 0; s < 3; s++) begin
            drive(1, 0, 8'd99, 0);
            chk($sformatf("stall%0d_in_ready", s), a_in_ready, 0);
            chk($sformatf("stall%0d_valid", s), a_win_valid, 1);
            chk($sformatf("stall%0d_win", s), a_win, full(mkw(1, 2, 3, 4, 5)));
        end
        @(negedge clk);
        in_valid = 1'b0;
        win_ready = 1'b1;
        #1;
        chk("release_in_ready", a_in_ready, 1);
        @(posedge clk);
        #1;
        chk("release_valid", a_win_valid, 0);
        for (int k = 6; k <= 10; k++) begin
            drive(1, 0, 8'(k), 1);
            chk($sformatf("post_stall_valid_%0d", k), a_win_valid, (k == 10));
        end
        chk("post_stall_win", a_win, full(mkw(6, 7, 8, 9, 10)));

        // Frame of 7 with in_last on the 7th, then a fresh frame
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            drive(1, (k == 7), 8'(k), 1);
            chk($sformatf("frame_valid_%0d", k), a_win_valid, (k == 5) || (PAD && k == 7));
            if (k == 5) chk("frame_win_5", a_win, full(mkw(1, 2, 3, 4, 5)));
        end
        if (PAD) begin
            pw = full(mkw(0, 0, 0, 6, 7));
            for (int c = 0; c < CH; c++)
                for (int i = 0; i < 3; i++) pw[c][i] = 8'h80;
            chk("frame_pad_win", a_win, pw);
        end
        for (int k = 11; k <= 15; k++) begin
            drive(1, 0, 8'(k), 1);
            chk($sformatf("frame2_valid_%0d", k), a_win_valid, (k == 15));
        end
        chk("frame2_win", a_win, full(mkw(11, 12, 13, 14, 15)));

        // Mid-frame asynchronous reset after 3 accepts
        for (int k = 21; k <= 23; k++) begin
            drive(1, 0, 8'(k), 1);
            chk($sformatf("pre_rst_valid_%0d", k), a_win_valid, 0);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", a_win_valid, 0);
        chk("mid_rst_win", a_win, 0);
        chk("mid_rst_in_ready", a_in_ready, 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 31; k <= 35; k++) begin
            drive(1, 0, 8'(k), 1);
            chk($sformatf("post_rst_valid_%0d", k), a_win_valid, (k == 35));
        end
        chk("post_rst_win", a_win, full(mkw(31, 32, 33, 34, 35)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
